tug_referee: RTL and testbench
==============================

TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of clock cycles a round win is displayed before the next round (legal 1-15).
REQ-002 Parameter MAX_SCORE, default 7: score that ends the game (legal 1-7).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 L  input  1  left-player push, one-cycle pulse, already synchronized.
REQ-006 R  input  1  right-player push, one-cycle pulse, already synchronized.
REQ-007 leftEnd  input  1  lightOn of the leftmost playfield light.
REQ-008 rightEnd  input  1  lightOn of the rightmost playfield light.
REQ-009 restart  output  1  one-cycle pulse that clears and recentres the playfield lights.
REQ-010 winner  output  2  round result: 00 none, 01 left, 10 right; 11 is never driven.
REQ-011 scoreL  output  3  left-player win count.
REQ-012 scoreR  output  3  right-player win count.
REQ-013 hexL  output  7  active-low 7-segment code of scoreL, bit order gfedcba.
REQ-014 hexR  output  7  active-low 7-segment code of scoreR, bit order gfedcba.

Function
REQ-015 The FSM SHALL have exactly four states: PLAY, LWIN, RWIN and OVER.
REQ-016 In PLAY, the block SHALL detect a left round win when leftEnd=1, rightEnd=0, L=1 and R=0 are sampled at the same edge.
REQ-017 In PLAY, the block SHALL detect a right round win when rightEnd=1, leftEnd=0, R=1 and L=0 are sampled at the same edge.
REQ-018 In PLAY, none of the following SHALL be a win: L=R=1, L=R=0, leftEnd=rightEnd=1 (illegal field), or an end light on with the opposite push.
REQ-019 At the edge that detects a win, the FSM SHALL enter LWIN or RWIN, set winner to 01 or 10, and increment the matching score, so all three are visible one cycle after the push.
REQ-020 Each score SHALL saturate at MAX_SCORE and never wrap.
REQ-021 The FSM SHALL remain in LWIN or RWIN for exactly HOLD_CYCLES cycles, counted by an internal 4-bit counter, and SHALL ignore L, R, leftEnd and rightEnd during that time.
REQ-022 On leaving LWIN or RWIN with the winner's score below MAX_SCORE, the FSM SHALL go to PLAY, set winner to 00, and drive restart=1 for exactly that first PLAY cycle.
REQ-023 On leaving LWIN or RWIN with the winner's score equal to MAX_SCORE, the FSM SHALL go to OVER, keep winner, and keep restart=0.
REQ-024 OVER SHALL be absorbing: winner and scores hold and all inputs are ignored until Reset.
REQ-025 restart SHALL be registered and asserted only as required by REQ-022.
REQ-026 hexL and hexR SHALL decode 0-7 combinationally from their score as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.

Reset
REQ-027 While Reset=1, the block SHALL asynchronously force state PLAY, winner=00, scoreL=scoreR=0, restart=0 and hold counter=0, so hexL=hexR=1000000.
REQ-028 Reset asserted in any state, including mid-hold or OVER, SHALL abort that state immediately without issuing restart.
REQ-029 After Reset deasserts, the first edge SHALL evaluate the win conditions in PLAY.

Verification
REQ-030 Left win: after reset, apply leftEnd=1 and L=1 for one cycle -> next cycle winner=01, scoreL=1, hexL=1111001; 4 cycles later winner=00 and restart=1 for 1 cycle.
REQ-031 Non-wins: apply leftEnd=1 with L=R=1, leftEnd=1 with R=1, and leftEnd=rightEnd=1 with L=1 -> scores unchanged, winner=00, no restart.
REQ-032 Hold masking: during RWIN hold, pulse R with rightEnd=1 -> scoreR increments only once.
REQ-033 Game end: drive 7 left wins -> after the 7th hold, state OVER, winner=01, scoreL=7, hexL=1111000, no restart; further pushes do nothing.
REQ-034 Reset mid-hold: assert Reset 2 cycles into LWIN -> immediately all outputs return to their reset values and no restart pulse occurs.
REQ-035 Parameter check: set HOLD_CYCLES=1 and MAX_SCORE=2 -> restart occurs 2 cycles after the push, and the second win goes to OVER.

Source files
------------

// File: rtl/tug_referee.sv
// Tug-of-war referee: detects round wins at the playfield ends, keeps saturating
// scores, holds each round result for HOLD_CYCLES and ends the game at MAX_SCORE.
module tug_referee #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_SCORE   = 7
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       L,
  input  logic       R,
  input  logic       leftEnd,
  input  logic       rightEnd,
  output logic       restart,
  output logic [1:0] winner,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic [6:0] hexL,
  output logic [6:0] hexR
);

  typedef enum logic [1:0] {PLAY, LWIN, RWIN, OVER} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] MAX_VAL   = 3'(MAX_SCORE);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] winner_n;
  logic [2:0] score_l_n, score_r_n;
  logic       restart_n;
  logic       left_win, right_win;

  assign left_win  = leftEnd && !rightEnd && L && !R;
  assign right_win = rightEnd && !leftEnd && R && !L;

  function automatic logic [6:0] seg(input logic [2:0] v);
    case (v)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
  endfunction

  assign hexL = seg(scoreL);
  assign hexR = seg(scoreR);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state   <= PLAY;
      cnt     <= 4'd0;
      winner  <= 2'b00;
      scoreL  <= 3'd0;
      scoreR  <= 3'd0;
      restart <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      winner  <= winner_n;
      scoreL  <= score_l_n;
      scoreR  <= score_r_n;
      restart <= restart_n;
    end
  end

  // The winner's score decides between another round and game over.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    winner_n  = winner;
    score_l_n = scoreL;
    score_r_n = scoreR;
    restart_n = 1'b0;
    case (state)
      PLAY: begin
        winner_n = 2'b00;
        if (left_win) begin
          state_n   = LWIN;
          winner_n  = 2'b01;
          cnt_n     = 4'd0;
          score_l_n = (scoreL < MAX_VAL) ? scoreL + 3'd1 : scoreL;
        end else if (right_win) begin
          state_n   = RWIN;
          winner_n  = 2'b10;
          cnt_n     = 4'd0;
          score_r_n = (scoreR < MAX_VAL) ? scoreR + 3'd1 : scoreR;
        end
      end
      LWIN, RWIN: begin
        if (cnt == HOLD_LAST) begin
          cnt_n = 4'd0;
          if (((state == LWIN) ? scoreL : scoreR) == MAX_VAL) begin
            state_n = OVER;
          end else begin
            state_n   = PLAY;
            winner_n  = 2'b00;
            restart_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = OVER;
    endcase
  end

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee: a default instance plus a HOLD_CYCLES=1,
// MAX_SCORE=2 instance, checked with immediate assertions.
module tb_tug_referee;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       L = 1'b0, R = 1'b0, leftEnd = 1'b0, rightEnd = 1'b0;
  logic       l2 = 1'b0, r2 = 1'b0, left_end2 = 1'b0, right_end2 = 1'b0;
  logic       restart, restart2;
  logic [1:0] winner, winner2;
  logic [2:0] scoreL, scoreR, score_l2, score_r2;
  logic [6:0] hexL, hexR, hex_l2, hex_r2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tug_referee dut (
    .clk(clk), .Reset(Reset), .L(L), .R(R), .leftEnd(leftEnd), .rightEnd(rightEnd),
    .restart(restart), .winner(winner), .scoreL(scoreL), .scoreR(scoreR),
    .hexL(hexL), .hexR(hexR)
  );

  tug_referee #(.HOLD_CYCLES(1), .MAX_SCORE(2)) dut2 (
    .clk(clk), .Reset(Reset), .L(l2), .R(r2), .leftEnd(left_end2), .rightEnd(right_end2),
    .restart(restart2), .winner(winner2), .scoreL(score_l2), .scoreR(score_r2),
    .hexL(hex_l2), .hexR(hex_r2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs to the default instance, then returns them to idle.
  task automatic applyStimulus(input logic le, input logic re, input logic l, input logic r);
    leftEnd = le; rightEnd = re; L = l; R = r;
    tick();
    leftEnd = 1'b0; rightEnd = 1'b0; L = 1'b0; R = 1'b0;
  endtask

  task automatic checkIdle(input string tag, input logic [2:0] sl, input logic [2:0] sr);
    checkOutput({tag, "_winner"}, 7'(winner), 7'd0);
    checkOutput({tag, "_restart"}, 7'(restart), 7'd0);
    checkOutput({tag, "_scoreL"}, 7'(scoreL), 7'(sl));
    checkOutput({tag, "_scoreR"}, 7'(scoreR), 7'(sr));
  endtask

  initial begin
    #2;
    checkIdle("reset", 3'd0, 3'd0);
    checkOutput("reset_hexL", hexL, 7'b1000000);
    checkOutput("reset_hexR", hexR, 7'b1000000);
    tick();
    Reset = 1'b0;

    applyStimulus(1, 0, 1, 1);
    checkIdle("nowin_LR", 3'd0, 3'd0);
    applyStimulus(1, 0, 0, 1);
    checkIdle("nowin_leR", 3'd0, 3'd0);
    applyStimulus(1, 1, 1, 0);
    checkIdle("nowin_both_ends", 3'd0, 3'd0);
    applyStimulus(0, 1, 1, 0);
    checkIdle("nowin_reL", 3'd0, 3'd0);

    applyStimulus(1, 0, 1, 0);
    checkOutput("lwin_winner", 7'(winner), 7'd1);
    checkOutput("lwin_scoreL", 7'(scoreL), 7'd1);
    checkOutput("lwin_hexL", hexL, 7'b1111001);
    checkOutput("lwin_restart", 7'(restart), 7'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("lwin_hold_winner", 7'(winner), 7'd1);
      checkOutput("lwin_hold_restart", 7'(restart), 7'd0);
    end
    tick();
    checkOutput("lwin_end_winner", 7'(winner), 7'd0);
    checkOutput("lwin_end_restart", 7'(restart), 7'd1);
    tick();
    checkOutput("lwin_restart_drop", 7'(restart), 7'd0);

    applyStimulus(0, 1, 0, 1);
    checkOutput("rwin_winner", 7'(winner), 7'd2);
    checkOutput("rwin_scoreR", 7'(scoreR), 7'd1);
    tick();
    applyStimulus(0, 1, 0, 1);
    checkOutput("mask_scoreR", 7'(scoreR), 7'd1);
    checkOutput("mask_winner", 7'(winner), 7'd2);
    tick();
    tick();
    checkOutput("rwin_end_restart", 7'(restart), 7'd1);
    checkOutput("rwin_end_winner", 7'(winner), 7'd0);
    checkOutput("rwin_end_scoreR", 7'(scoreR), 7'd1);
    checkOutput("rwin_end_hexR", hexR, 7'b1111001);
    tick();
    checkOutput("rwin_restart_drop", 7'(restart), 7'd0);

    for (int i = 2; i <= 7; i++) begin
      applyStimulus(1, 0, 1, 0);
      checkOutput("game_scoreL", 7'(scoreL), 7'(i));
      for (int k = 0; k < 4; k++) tick();
      checkOutput("game_restart", 7'(restart), (i < 7) ? 7'd1 : 7'd0);
      checkOutput("game_winner", 7'(winner), (i < 7) ? 7'd0 : 7'd1);
    end
    checkOutput("over_hexL", hexL, 7'b1111000);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1);
    tick();
    checkOutput("over_scoreL", 7'(scoreL), 7'd7);
    checkOutput("over_scoreR", 7'(scoreR), 7'd1);
    checkOutput("over_winner", 7'(winner), 7'd1);
    checkOutput("over_restart", 7'(restart), 7'd0);

    Reset = 1'b1;
    #2;
    checkIdle("over_reset", 3'd0, 3'd0);
    checkOutput("over_reset_hexL", hexL, 7'b1000000);
    tick();
    Reset = 1'b0;

    // The very first edge after release must already score.
    applyStimulus(1, 0, 1, 0);
    checkOutput("post_reset_win", 7'(winner), 7'd1);
    tick();
    tick();
    Reset = 1'b1;
    #2;
    checkIdle("midhold_reset", 3'd0, 3'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("midhold_no_restart", 7'(restart), 7'd0);
    end
    checkOutput("midhold_winner", 7'(winner), 7'd0);

    left_end2 = 1'b1; l2 = 1'b1;
    tick();
    left_end2 = 1'b0; l2 = 1'b0;
    checkOutput("p2_win1_winner", 7'(winner2), 7'd1);
    checkOutput("p2_win1_restart", 7'(restart2), 7'd0);
    tick();
    checkOutput("p2_restart", 7'(restart2), 7'd1);
    checkOutput("p2_restart_winner", 7'(winner2), 7'd0);
    tick();
    checkOutput("p2_restart_drop", 7'(restart2), 7'd0);
    left_end2 = 1'b1; l2 = 1'b1;
    tick();
    left_end2 = 1'b0; l2 = 1'b0;
    checkOutput("p2_win2_score", 7'(score_l2), 7'd2);
    tick();
    checkOutput("p2_over_winner", 7'(winner2), 7'd1);
    checkOutput("p2_over_restart", 7'(restart2), 7'd0);
    checkOutput("p2_over_hexL", hex_l2, 7'b0100100);
    left_end2 = 1'b1; l2 = 1'b1;
    tick();
    left_end2 = 1'b0; l2 = 1'b0;
    tick();
    checkOutput("p2_over_hold_score", 7'(score_l2), 7'd2);
    checkOutput("p2_over_hold_restart", 7'(restart2), 7'd0);
    checkOutput("p2_scoreR", 7'(score_r2), 7'd0);
    checkOutput("p2_hexR", hex_r2, 7'b1000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
